uart_echo_tester: RTL and testbench
===================================

Name: uart_echo_tester

Overview:
Initiator side of the UART echo link. The far end echoes every received byte back incremented by one; this block drives that exchange and checks the result.
- Connects to the FIFO-side interface of a uart_module instance.
- Sends a sequence of bytes, waits for each echo and checks that echo == sent + 1 (mod 256).
- Counts passes, mismatches and timeouts for on-board self-test of the echo link.

Parameters:
NUM_BYTES, 256, bytes sent per test run (1..65535).
START_BYTE, 8'h00, first byte value sent; each later byte is +1, wrapping mod 256.
TIMEOUT_CYCLES, 1_000_000, cycles to wait for an echo before declaring a timeout (>= 2).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a run when idle
w_data  out  8  byte to TX FIFO
wr_uart  out  1  TX FIFO write strobe, one cycle per byte
tx_full  in  1  TX FIFO full
r_data  in  8  RX FIFO head (show-ahead, valid when rx_empty=0)
rd_uart  out  1  RX FIFO pop strobe, one cycle
rx_empty  in  1  RX FIFO empty
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
ok_cnt  out  16  correct echoes this run
err_cnt  out  16  mismatching echoes this run
tmo_cnt  out  16  timeouts this run
last_rx  out  8  last byte popped from the RX FIFO

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: every output is 0, and the FSM is in IDLE.
- Registered outputs: all outputs are registered. wr_uart and rd_uart are never high for two consecutive cycles.
- IDLE:
  - busy=0.
  - When start=1: clear ok/err/tmo counters, set cur=START_BYTE, idx=0, go to FLUSH.
  - start while busy is ignored.
- FLUSH (discard stale echoes):
  - While rx_empty=0, pulse rd_uart, one pop per two cycles (pop, then re-sample).
  - When rx_empty=1, go to SEND.
  - Flushed bytes do not update counters or last_rx.
- SEND:
  - While tx_full=1, wait.
  - Otherwise, for one cycle: wr_uart=1 and w_data=cur. Clear the timer and go to WAIT.
  - w_data holds cur until the next SEND.
- WAIT:
  - Timer increments each cycle.
  - If rx_empty=0, go to CHECK. This takes priority over timeout in the same cycle.
  - Else if timer == TIMEOUT_CYCLES-1: tmo_cnt++, go to NEXT.
- CHECK:
  - For one cycle: rd_uart=1 and last_rx=r_data.
  - If r_data == cur+8'd1 (8-bit wrap: 8'hFF expects 8'h00), ok_cnt++; else err_cnt++.
  - Go to NEXT.
- NEXT:
  - If idx == NUM_BYTES-1, go to DONE.
  - Else idx++, cur++ (mod 256), go to SEND.
- DONE: done=1 for one cycle, then IDLE. Counters hold their values until the next accepted start.
- busy=1 in every state except IDLE.
- Counter saturation: all counters saturate at 16'hFFFF.
- Late echoes: an echo arriving after its timeout remains in the RX FIFO. It is consumed by the next CHECK and normally produces a mismatch. This is intended: it reports link skew.
- Reset mid-run: aborts immediately to IDLE with all outputs 0. No partial done pulse.
- Round-trip latency per byte: about 4 cycles of block overhead plus the link round trip.

Decomposition:
- Package uart_echo_pkg:
  - State enum: IDLE, FLUSH, SEND, WAIT, CHECK, NEXT, DONE.
  - Constant ECHO_INC = 8'd1.
  - Counter width localparam CNT_W = 16.
- Sub-module sat_counter (width-parametrised, with clear, increment and saturate), instanced three times for ok, err and tmo.
- FSM, timer and data path stay in the top module.

Test Plan:
- Loopback model returning byte+1 after 50 cycles; NUM_BYTES=4, START_BYTE=8'hFD; pulse start -> w_data sequence FD, FE, FF, 00; ok_cnt=4, err_cnt=0, tmo_cnt=0; last_rx=8'h01; done pulses once; busy falls the cycle after done.
- Model returns byte+2 for the third byte only (NUM_BYTES=4) -> ok_cnt=3, err_cnt=1.
- Model drops the second byte; TIMEOUT_CYCLES=100 -> tmo_cnt=1, ok_cnt=NUM_BYTES-1; exactly 100 cycles between wr_uart and the move to NEXT for that byte.
- 3 stale bytes preloaded in the RX FIFO before start -> exactly 3 rd_uart pulses precede the first wr_uart; counters unaffected.
- tx_full held high 20 cycles at the first SEND -> no wr_uart until the cycle after tx_full falls; start pulses during the run are ignored.
- rst asserted mid-WAIT -> all outputs 0 asynchronously; a new start after release performs a clean full run with correct counts.

Source files
------------

// File: rtl/uart_echo_pkg.sv
// rtl/uart_echo_pkg.sv - shared states and constants for the UART echo link tester
package uart_echo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        SEND,
        WAIT,
        CHECK,
        NEXT,
        DONE
    } echo_state_t;

    localparam logic [7:0] ECHO_INC = 8'd1;
    localparam int         CNT_W    = 16;

    function automatic logic [7:0] expected_echo(input logic [7:0] sent);
        return sent + ECHO_INC;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter with synchronous clear that sticks at all-ones
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/uart_echo_tester.sv
// rtl/uart_echo_tester.sv - UART echo link initiator: sends bytes, checks echo == sent + 1
module uart_echo_tester
    import uart_echo_pkg::*;
#(
    parameter int         NUM_BYTES      = 256,
    parameter logic [7:0] START_BYTE     = 8'h00,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [7:0]       w_data,
    output logic             wr_uart,
    input  logic             tx_full,
    input  logic [7:0]       r_data,
    output logic             rd_uart,
    input  logic             rx_empty,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] tmo_cnt,
    output logic [7:0]       last_rx
);

    localparam int               TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]      IDX_LAST = 16'(NUM_BYTES - 1);

    echo_state_t      r_state;
    echo_state_t      w_next_state;
    logic [7:0]       r_cur;
    logic [15:0]      r_idx;
    logic [TMO_W-1:0] r_timer;
    logic             r_flush_hold;
    logic [7:0]       r_tx_byte;
    logic             r_wr_uart;
    logic             r_rd_uart;
    logic [7:0]       r_last_rx;
    logic             r_busy;
    logic             r_done;

    logic w_wr;
    logic w_rd;
    logic w_flush_hold;
    logic w_load_rx;
    logic w_clr;
    logic w_run_init;
    logic w_idx_step;
    logic w_timer_clr;
    logic w_timer_inc;
    logic w_ok_inc;
    logic w_err_inc;
    logic w_tmo_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_wr         = 1'b0;
        w_rd         = 1'b0;
        w_flush_hold = 1'b0;
        w_load_rx    = 1'b0;
        w_clr        = 1'b0;
        w_run_init   = 1'b0;
        w_idx_step   = 1'b0;
        w_timer_clr  = 1'b0;
        w_timer_inc  = 1'b0;
        w_ok_inc     = 1'b0;
        w_err_inc    = 1'b0;
        w_tmo_inc    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_clr        = 1'b1;
                    w_run_init   = 1'b1;
                    w_next_state = FLUSH;
                end
            end
            FLUSH: begin
                // After each pop skip one cycle so rx_empty reflects the popped FIFO.
                if (!r_flush_hold) begin
                    if (!rx_empty) begin
                        w_rd         = 1'b1;
                        w_flush_hold = 1'b1;
                    end else begin
                        w_next_state = SEND;
                    end
                end
            end
            SEND: begin
                if (!tx_full) begin
                    w_wr         = 1'b1;
                    w_timer_clr  = 1'b1;
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (!rx_empty) begin
                    w_next_state = CHECK;
                end else if (r_timer == TMO_LAST) begin
                    w_tmo_inc    = 1'b1;
                    w_next_state = NEXT;
                end else begin
                    w_timer_inc = 1'b1;
                end
            end
            CHECK: begin
                w_rd      = 1'b1;
                w_load_rx = 1'b1;
                if (r_data == expected_echo(r_cur)) begin
                    w_ok_inc = 1'b1;
                end else begin
                    w_err_inc = 1'b1;
                end
                w_next_state = NEXT;
            end
            NEXT: begin
                if (r_idx == IDX_LAST) begin
                    w_next_state = DONE;
                end else begin
                    w_idx_step   = 1'b1;
                    w_next_state = SEND;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur        <= '0;
            r_idx        <= '0;
            r_timer      <= '0;
            r_flush_hold <= 1'b0;
            r_tx_byte    <= '0;
            r_wr_uart    <= 1'b0;
            r_rd_uart    <= 1'b0;
            r_last_rx    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_flush_hold <= w_flush_hold;
            r_wr_uart    <= w_wr;
            r_rd_uart    <= w_rd;
            r_busy       <= (w_next_state != IDLE);
            r_done       <= (w_next_state == DONE);
            if (w_run_init) begin
                r_cur <= START_BYTE;
                r_idx <= '0;
            end else if (w_idx_step) begin
                r_cur <= r_cur + 8'd1;
                r_idx <= r_idx + 16'd1;
            end
            if (w_timer_clr) begin
                r_timer <= '0;
            end else if (w_timer_inc) begin
                r_timer <= r_timer + TMO_W'(1);
            end
            if (w_wr) begin
                r_tx_byte <= r_cur;
            end
            if (w_load_rx) begin
                r_last_rx <= r_data;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_ok_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .inc   (w_ok_inc),
        .count (ok_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .inc   (w_err_inc),
        .count (err_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_tmo_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .inc   (w_tmo_inc),
        .count (tmo_cnt)
    );

    assign w_data  = r_tx_byte;
    assign wr_uart = r_wr_uart;
    assign rd_uart = r_rd_uart;
    assign busy    = r_busy;
    assign done    = r_done;
    assign last_rx = r_last_rx;

endmodule

// File: tb/tb_uart_echo_tester.sv
// tb/tb_uart_echo_tester.sv - scoreboard bench for uart_echo_tester with an echo loopback model
module tb_uart_echo_tester;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  w_data;
    logic        wr_uart;
    logic        tx_full = 1'b0;
    logic [7:0]  r_data = 8'h00;
    logic        rd_uart;
    logic        rx_empty = 1'b1;
    logic        busy;
    logic        done;
    logic [15:0] ok_cnt;
    logic [15:0] err_cnt;
    logic [15:0] tmo_cnt;
    logic [7:0]  last_rx;

    uart_echo_tester #(
        .NUM_BYTES      (4),
        .START_BYTE     (8'hFD),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .w_data   (w_data),
        .wr_uart  (wr_uart),
        .tx_full  (tx_full),
        .r_data   (r_data),
        .rd_uart  (rd_uart),
        .rx_empty (rx_empty),
        .busy     (busy),
        .done     (done),
        .ok_cnt   (ok_cnt),
        .err_cnt  (err_cnt),
        .tmo_cnt  (tmo_cnt),
        .last_rx  (last_rx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] val;
    } pend_t;

    typedef struct {
        int          flush;
        bit          txf;
        logic [15:0] ok;
        logic [15:0] err;
        logic [15:0] tmo;
        logic [7:0]  last;
    } run_t;

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         stale_req = 0;
    int         stale_done = 0;
    bit         drop_en = 1'b0;
    bit         bad_en = 1'b0;
    logic [7:0] drop_val = 8'h00;
    logic [7:0] bad_val = 8'h00;

    logic [7:0] rxq[$];
    pend_t      pend[$];
    logic [7:0] wexp[$];
    run_t       rexp[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Loopback: echo byte+1 (or +2 / dropped on request) 50 cycles after the write.
    always @(negedge clk) begin
        while (stale_done < stale_req) begin
            rxq.push_back(8'(8'h50 + stale_done));
            stale_done++;
        end
        if (rd_uart && rxq.size() > 0) void'(rxq.pop_front());
        if (wr_uart && !(drop_en && w_data == drop_val)) begin
            pend.push_back('{cyc + 50, w_data + ((bad_en && w_data == bad_val) ? 8'd2 : 8'd1)});
        end
        while (pend.size() > 0 && pend[0].due <= cyc) begin
            rxq.push_back(pend[0].val);
            void'(pend.pop_front());
        end
        rx_empty = (rxq.size() == 0);
        r_data   = rx_empty ? 8'h00 : rxq[0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string pfx);
        check({pfx, "_busy"}, 32'(busy), 0);
        check({pfx, "_done"}, 32'(done), 0);
        check({pfx, "_strobes"}, 32'({wr_uart, rd_uart}), 0);
        check({pfx, "_w_data"}, 32'(w_data), 0);
        check({pfx, "_last_rx"}, 32'(last_rx), 0);
        check({pfx, "_ok_cnt"}, 32'(ok_cnt), 0);
        check({pfx, "_err_cnt"}, 32'(err_cnt), 0);
        check({pfx, "_tmo_cnt"}, 32'(tmo_cnt), 0);
    endtask

    task automatic push_exp(input int flush, input bit txf, input logic [15:0] ok,
                            input logic [15:0] err, input logic [15:0] tmo, input logic [7:0] last);
        logic [7:0] b;
        b = 8'hFD;
        for (int i = 0; i < 4; i++) begin
            wexp.push_back(b);
            b = b + 8'd1;
        end
        rexp.push_back('{flush, txf, ok, err, tmo, last});
    endtask

    task automatic pulse_start();
        @(posedge clk) #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) check({name, "_run_timeout"}, 32'(seen), 1);
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_wr();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            seen = wr_uart;
        end
        if (!seen) check("wr_wait_timeout", 32'(seen), 1);
    endtask

    task automatic monitor_loop();
        bit   prev_busy = 1'b0;
        bit   prev_wr = 1'b0;
        bit   prev_rd = 1'b0;
        bit   prev_txf = 1'b0;
        bit   run_wr_seen = 1'b0;
        bit   chk_busy_low = 1'b0;
        int   rd_cnt = 0;
        int   last_wr_cyc = 0;
        int   txf_fall_cyc = 0;
        logic [15:0] prev_tmo = 16'h0;
        run_t r;
        forever begin
            @(negedge clk);
            if (prev_txf && !tx_full) txf_fall_cyc = cyc;
            prev_txf = tx_full;
            if (rst) begin
                prev_busy    = 1'b0;
                prev_wr      = 1'b0;
                prev_rd      = 1'b0;
                chk_busy_low = 1'b0;
                prev_tmo     = 16'h0;
            end else begin
                if (chk_busy_low) begin
                    check("busy_after_done", 32'(busy), 0);
                    chk_busy_low = 1'b0;
                end
                if (busy && !prev_busy) begin
                    run_wr_seen = 1'b0;
                    rd_cnt      = 0;
                end
                if (wr_uart) check("wr_gap", 32'(prev_wr), 0);
                if (rd_uart) check("rd_gap", 32'(prev_rd), 0);
                if (rd_uart && !run_wr_seen) rd_cnt++;
                if (wr_uart) begin
                    last_wr_cyc = cyc;
                    if (wexp.size() == 0) check("wr_unexpected", 32'(wr_uart), 0);
                    else check("w_data", 32'(w_data), 32'(wexp.pop_front()));
                    if (!run_wr_seen && rexp.size() > 0) begin
                        check("flush_pops", 32'(rd_cnt), 32'(rexp[0].flush));
                        if (rexp[0].txf) check("tx_full_release", 32'(cyc), 32'(txf_fall_cyc + 1));
                    end
                    run_wr_seen = 1'b1;
                end
                if (tmo_cnt > prev_tmo) check("timeout_cycles", 32'(cyc - last_wr_cyc), 100);
                if (done) begin
                    if (rexp.size() == 0) begin
                        check("done_unexpected", 32'(done), 0);
                    end else begin
                        r = rexp.pop_front();
                        check("ok_cnt", 32'(ok_cnt), 32'(r.ok));
                        check("err_cnt", 32'(err_cnt), 32'(r.err));
                        check("tmo_cnt", 32'(tmo_cnt), 32'(r.tmo));
                        check("last_rx", 32'(last_rx), 32'(r.last));
                        check("busy_at_done", 32'(busy), 1);
                    end
                    chk_busy_low = 1'b1;
                end
                prev_busy = busy;
                prev_wr   = wr_uart;
                prev_rd   = rd_uart;
                prev_tmo  = tmo_cnt;
            end
        end
    endtask

    initial begin
        fork
            monitor_loop();
        join_none

        repeat (3) @(posedge clk);
        #1 check_idle("reset");
        @(posedge clk) #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        // Clean run across the FF->00 wrap.
        push_exp(0, 1'b0, 16'd4, 16'd0, 16'd0, 8'h01);
        pulse_start();
        wait_done("clean");

        // Third byte (FF) echoed as +2.
        bad_en = 1'b1;
        bad_val = 8'hFF;
        push_exp(0, 1'b0, 16'd3, 16'd1, 16'd0, 8'h01);
        pulse_start();
        wait_done("bad_echo");
        bad_en = 1'b0;

        // Second byte (FE) never echoed.
        drop_en = 1'b1;
        drop_val = 8'hFE;
        push_exp(0, 1'b0, 16'd3, 16'd0, 16'd1, 8'h01);
        pulse_start();
        wait_done("drop");
        drop_en = 1'b0;

        // Three stale bytes waiting in the RX FIFO.
        stale_req = stale_req + 3;
        repeat (3) @(posedge clk);
        push_exp(3, 1'b0, 16'd4, 16'd0, 16'd0, 8'h01);
        pulse_start();
        wait_done("stale");

        // TX FIFO full at the first SEND, extra starts while busy.
        @(posedge clk) #1 tx_full = 1'b1;
        push_exp(0, 1'b1, 16'd4, 16'd0, 16'd0, 8'h01);
        pulse_start();
        repeat (6) @(posedge clk);
        pulse_start();
        repeat (10) @(posedge clk);
        #1 tx_full = 1'b0;
        wait_wr();
        repeat (5) @(posedge clk);
        pulse_start();
        wait_done("tx_full");

        // Asynchronous reset in WAIT, then a clean run (the orphan echo gets flushed).
        push_exp(0, 1'b0, 16'd4, 16'd0, 16'd0, 8'h01);
        pulse_start();
        wait_wr();
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_idle("mid_rst");
        wexp.delete();
        rexp.delete();
        @(posedge clk) #1 rst = 1'b0;
        repeat (80) @(posedge clk);
        push_exp(1, 1'b0, 16'd4, 16'd0, 16'd0, 8'h01);
        pulse_start();
        wait_done("after_rst");

        check("leftover_bytes", 32'(wexp.size()), 0);
        check("leftover_runs", 32'(rexp.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
